hvtx_pattern: RTL and testbench

//  Test-pattern pixel source for the HDMI TX path. Consumes the free-running x/y cursor
//  and produces the 24-bit pixel feeding the TMDS modulator's video input. 2-cycle

---
 rtl/hvtx_pkg.sv | 30 +++
 rtl/hvtx_bar_index.sv | 54 +++++
 rtl/hvtx_pattern.sv | 143 ++++++++++++++
 tb/tb_hvtx_pattern.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hvtx_pkg.sv
// Shared types and constants for the HDMI TX test-pattern generator.
// Pixel layout is {R,G,B} = channels {2,1,0}.
package hvtx_pkg;

    typedef logic [2:0][7:0] rgb_t;

    typedef enum logic [2:0] {
        PAT_SOLID = 3'd0,
        PAT_BARS  = 3'd1,
        PAT_HGRAD = 3'd2,
        PAT_VGRAD = 3'd3,
        PAT_CHECK = 3'd4
    } pattern_e;

    // Classic 8-bar sequence, left to right; the last bar also covers any overflow.
    localparam rgb_t BAR_LUT [8] = '{
        24'hFFFFFF,
        24'hFFFF00,
        24'h00FFFF,
        24'h00FF00,
        24'hFF00FF,
        24'hFF0000,
        24'h0000FF,
        24'h000000
    };

    localparam rgb_t RGB_WHITE = 24'hFFFFFF;
    localparam rgb_t RGB_BLACK = 24'h000000;

endpackage

// File: rtl/hvtx_bar_index.sv
// Colour-bar index tracker: counts pixels within the current bar and steps a
// saturating 3-bit bar index, restarting whenever the cursor returns to x==0.
module hvtx_bar_index #(
    parameter int WID   = 12,
    parameter int BAR_W = 160
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [WID-1:0] x,
    output logic [2:0]     idx
);

    localparam int            CW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [CW-1:0] PIX_LAST = CW'(BAR_W - 1);

    logic [CW-1:0] pix_reg;
    logic [CW-1:0] pix_next;
    logic [CW-1:0] pix_cur;
    logic [2:0]    idx_reg;
    logic [2:0]    idx_next;
    logic [2:0]    idx_cur;

    // The registers hold the position expected for the next pixel; x==0 overrides
    // them so the line start is always correct even after a cursor jump or reset.
    always_comb begin
        pix_cur  = pix_reg;
        idx_cur  = idx_reg;
        if (x == '0) begin
            pix_cur = '0;
            idx_cur = '0;
        end
        pix_next = pix_cur + CW'(1);
        idx_next = idx_cur;
        if (pix_cur == PIX_LAST) begin
            pix_next = '0;
            if (idx_cur != 3'd7) begin
                idx_next = idx_cur + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pix_reg <= '0;
            idx_reg <= '0;
        end else begin
            pix_reg <= pix_next;
            idx_reg <= idx_next;
        end
    end

    assign idx = idx_cur;

endmodule

// File: rtl/hvtx_pattern.sv
// Test-pattern pixel source for the HDMI TX path: two-stage pipeline from the
// x/y cursor to a 24-bit pixel, with frame-synchronous mode latching.
module hvtx_pattern
    import hvtx_pkg::*;
#(
    parameter int WID           = 12,
    parameter int ACTIVE_WIDTH  = 1280,
    parameter int ACTIVE_HEIGHT = 720,
    parameter int BAR_W         = 160,
    parameter int CHK_LOG2      = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [WID-1:0]  i_x,
    input  logic [WID-1:0]  i_y,
    input  logic [2:0]      i_mode,
    input  logic [2:0][7:0] i_fg,
    output logic [2:0][7:0] o_video,
    output logic            o_sof
);

    logic       frame_start;
    logic [2:0] mode_reg;
    logic [7:0] frame_cnt_reg;
    logic [2:0] mode_cur;
    logic [7:0] frame_cnt_cur;
    logic       active;
    logic [2:0] bar_idx;
    logic [7:0] grad_next;

    assign frame_start = (i_x == '0) && (i_y == '0);
    assign active      = (i_x < WID'(ACTIVE_WIDTH)) && (i_y < WID'(ACTIVE_HEIGHT));

    // At frame start the newly requested mode and count already apply to pixel (0,0).
    always_comb begin
        mode_cur      = mode_reg;
        frame_cnt_cur = frame_cnt_reg;
        if (frame_start) begin
            mode_cur      = i_mode;
            frame_cnt_cur = frame_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_reg      <= PAT_SOLID;
            frame_cnt_reg <= '0;
        end else if (frame_start) begin
            mode_reg      <= mode_cur;
            frame_cnt_reg <= frame_cnt_cur;
        end
    end

    hvtx_bar_index #(
        .WID   (WID),
        .BAR_W (BAR_W)
    ) u_bar_index (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .x     (i_x),
        .idx   (bar_idx)
    );

    always_comb begin
        grad_next = '0;
        case (mode_cur)
            PAT_HGRAD: grad_next = i_x[7:0] + frame_cnt_cur;
            PAT_VGRAD: grad_next = i_y[7:0] + frame_cnt_cur;
            default:   grad_next = '0;
        endcase
    end

    // Stage 0: per-pixel attributes.
    logic       s0_active_reg;
    logic [2:0] s0_mode_reg;
    logic [2:0] s0_idx_reg;
    logic       s0_chk_reg;
    logic [7:0] s0_grad_reg;
    rgb_t       s0_fg_reg;
    logic       s0_sof_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s0_active_reg <= 1'b0;
            s0_mode_reg   <= PAT_SOLID;
            s0_idx_reg    <= '0;
            s0_chk_reg    <= 1'b0;
            s0_grad_reg   <= '0;
            s0_fg_reg     <= '0;
            s0_sof_reg    <= 1'b0;
        end else begin
            s0_active_reg <= active;
            s0_mode_reg   <= mode_cur;
            s0_idx_reg    <= bar_idx;
            s0_chk_reg    <= i_x[CHK_LOG2] ^ i_y[CHK_LOG2];
            s0_grad_reg   <= grad_next;
            s0_fg_reg     <= i_fg;
            s0_sof_reg    <= frame_start;
        end
    end

    rgb_t grey_rgb;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_grey
            assign grey_rgb[gi] = s0_grad_reg;
        end
    endgenerate

    // Stage 1: pattern mux.
    rgb_t video_next;
    rgb_t video_reg;
    logic sof_reg;

    always_comb begin
        video_next = RGB_BLACK;
        if (s0_active_reg) begin
            case (s0_mode_reg)
                PAT_SOLID: video_next = s0_fg_reg;
                PAT_BARS:  video_next = BAR_LUT[s0_idx_reg];
                PAT_HGRAD: video_next = grey_rgb;
                PAT_VGRAD: video_next = grey_rgb;
                PAT_CHECK: video_next = s0_chk_reg ? RGB_WHITE : RGB_BLACK;
                default:   video_next = RGB_BLACK;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            video_reg <= '0;
            sof_reg   <= 1'b0;
        end else begin
            video_reg <= video_next;
            sof_reg   <= s0_sof_reg;
        end
    end

    assign o_video = video_reg;
    assign o_sof   = sof_reg;

endmodule

// File: tb/tb_hvtx_pattern.sv
// Bench for hvtx_pattern: behavioural pixel model plus a table of fixed points
// for the directed scenarios, followed by randomized cursor segments.
module tb_hvtx_pattern;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [11:0]     i_x = '0;
    logic [11:0]     i_y = '0;
    logic [2:0]      i_mode = '0;
    logic [2:0][7:0] i_fg = '0;
    logic [2:0][7:0] o_video;
    logic            o_sof;

    always #5 i_clk = ~i_clk;

    hvtx_pattern #(
        .WID           (12),
        .ACTIVE_WIDTH  (1280),
        .ACTIVE_HEIGHT (720),
        .BAR_W         (160),
        .CHK_LOG2      (5)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_x     (i_x),
        .i_y     (i_y),
        .i_mode  (i_mode),
        .i_fg    (i_fg),
        .o_video (o_video),
        .o_sof   (o_sof)
    );

    int checks   = 0;
    int failures = 0;
    int phase    = 0;

    // Reference model state
    int m_mode  = 0;
    int m_cnt   = 0;
    bit m_run   = 0;
    int m_lastx = 0;

    typedef struct {
        logic [23:0] video;
        logic        sof;
        bit          known;
        bit          has_vec;
        logic [23:0] vec_val;
        int          vx;
        int          vy;
    } exp_t;

    typedef struct {
        int          ph;
        int          x;
        int          y;
        logic [23:0] video;
    } vec_t;

    exp_t q[$];
    vec_t vecs[$];

    function automatic logic [23:0] bar_color(int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] ref_pixel(int x, int y, logic [23:0] fg, int mode,
                                              int cnt, bit run_ok, output bit known);
        int bi;
        logic [7:0] g;
        known = 1;
        if (x >= 1280 || y >= 720) return 24'h0;
        case (mode)
            0: return fg;
            1: begin
                if (!run_ok) begin
                    known = 0;
                    return 24'h0;
                end
                bi = x / 160;
                if (bi > 7) bi = 7;
                return bar_color(bi);
            end
            2: begin
                g = 8'((x + cnt) % 256);
                return {g, g, g};
            end
            3: begin
                g = 8'((y + cnt) % 256);
                return {g, g, g};
            end
            4: return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            default: return 24'h0;
        endcase
    endfunction

    task automatic add_vec(int ph, int x, int y, logic [23:0] v);
        vec_t r;
        r.ph = ph; r.x = x; r.y = y; r.video = v;
        vecs.push_back(r);
    endtask

    task automatic check(exp_t e);
        checks++;
        if (o_sof !== e.sof) begin
            failures++;
            $display("FAIL sof at (%0d,%0d): got %b want %b", e.vx, e.vy, o_sof, e.sof);
        end
        if (e.known) begin
            checks++;
            if (o_video !== e.video) begin
                failures++;
                $display("FAIL model_pixel at (%0d,%0d): got %06h want %06h",
                         e.vx, e.vy, o_video, e.video);
            end
        end
        if (e.has_vec) begin
            checks++;
            if (o_video !== e.vec_val) begin
                failures++;
                $display("FAIL vector phase=%0d at (%0d,%0d): got %06h want %06h",
                         phase, e.vx, e.vy, o_video, e.vec_val);
            end else begin
                $display("vector phase=%0d (%0d,%0d) -> %06h ok", phase, e.vx, e.vy, o_video);
            end
        end
    endtask

    // One pixel clock: apply inputs, queue the expected result, check the pixel
    // whose result is now on the outputs (two cycles after it was applied).
    task automatic drive(int x, int y, int mode, logic [23:0] fg, bit rst);
        exp_t e;
        bit kn;
        @(negedge i_clk);
        i_x = 12'(x); i_y = 12'(y); i_mode = 3'(mode); i_fg = fg; i_rst = rst;
        e.vx = x; e.vy = y; e.has_vec = 0; e.vec_val = '0;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_run = 0;
            if (q.size() > 0) begin
                q[q.size()-1].video = '0;
                q[q.size()-1].sof   = 1'b0;
                q[q.size()-1].known = 1;
            end
            e.video = '0; e.sof = 1'b0; e.known = 1;
        end else begin
            if (x == 0 && y == 0) begin
                m_mode = mode;
                m_cnt  = (m_cnt + 1) % 256;
            end
            if (x == 0) m_run = 1;
            else if (!(m_run && x == m_lastx + 1)) m_run = 0;
            e.video = ref_pixel(x, y, fg, m_mode, m_cnt, m_run, kn);
            e.known = kn;
            e.sof   = (x == 0 && y == 0);
        end
        m_lastx = x;
        foreach (vecs[i]) begin
            if (vecs[i].ph == phase && vecs[i].x == x && vecs[i].y == y) begin
                e.has_vec = 1;
                e.vec_val = vecs[i].video;
            end
        end
        q.push_back(e);
        @(posedge i_clk);
        #1;
        if (q.size() == 2) check(q.pop_front());
    endtask

    task automatic run_line(int y, int x0, int x1, int mode, logic [23:0] fg);
        for (int x = x0; x <= x1; x++) drive(x, y, mode, fg, 0);
    endtask

    initial begin
        // Fixed expectations, grouped by scenario phase.
        add_vec(1, 640, 0, 24'h000000);
        for (int l = 0; l < 2; l++) begin
            int yy;
            yy = (l == 0) ? 0 : 719;
            add_vec(2, 0,    yy, 24'hFFFFFF);
            add_vec(2, 159,  yy, 24'hFFFFFF);
            add_vec(2, 160,  yy, 24'hFFFF00);
            add_vec(2, 799,  yy, 24'hFF00FF);
            add_vec(2, 800,  yy, 24'hFF0000);
            add_vec(2, 959,  yy, 24'hFF0000);
            add_vec(2, 960,  yy, 24'h0000FF);
            add_vec(2, 1279, yy, 24'h000000);
            add_vec(2, 1280, yy, 24'h000000);
        end
        add_vec(3, 650, 300, 24'hFF00FF);
        add_vec(3, 170, 301, 24'hFFFF00);
        add_vec(4, 0,  0,  24'h000000);
        add_vec(4, 32, 0,  24'hFFFFFF);
        add_vec(4, 0,  32, 24'hFFFFFF);
        add_vec(4, 32, 32, 24'h000000);
        add_vec(10, 5, 10, 24'h060606);
        add_vec(11, 5, 10, 24'h040404);
        add_vec(12, 5, 10, 24'h050505);
        add_vec(12, 0, 0,  24'h000000);
        add_vec(13, 5, 10, 24'h060606);
        add_vec(20, 1300, 10,  24'h000000);
        add_vec(20, 10,   725, 24'h000000);
        add_vec(20, 1649, 749, 24'h000000);
        add_vec(30, 700, 400, 24'h000000);
        add_vec(30, 701, 400, 24'hABCDEF);
        add_vec(30, 750, 400, 24'hABCDEF);
        add_vec(31, 0,   0,   24'hFFFFFF);
        add_vec(31, 160, 0,   24'hFFFF00);

        // Reset with the cursor parked at (0,0): frame 0 stays SOLID.
        phase = 1;
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 24'h0, 1);
        run_line(0, 1, 1300, 1, 24'h0);

        // Frame 1 in BARS, first and last active lines.
        phase = 2;
        run_line(0, 0, 1300, 1, 24'h0);
        run_line(719, 0, 1300, 1, 24'h0);

        // Mid-frame mode request is ignored until the next frame start.
        phase = 3;
        run_line(300, 0, 599, 1, 24'h112233);
        run_line(300, 600, 700, 4, 24'h112233);
        run_line(301, 0, 200, 4, 24'h112233);
        phase = 4;
        run_line(0, 0, 40, 4, 24'h0);
        run_line(32, 0, 40, 4, 24'h0);

        // Gradient across 257 frame starts: frame counter wraps.
        phase = 0;
        drive(100, 100, 2, 24'h0, 1);
        for (int n = 1; n <= 257; n++) begin
            phase = (n == 1) ? 10 : (n == 255) ? 11 : (n == 256) ? 12 : (n == 257) ? 13 : 0;
            drive(0, 0, 2, 24'h0, 0);
            drive(5, 10, 2, 24'h0, 0);
        end

        // Blanking is black in every mode.
        phase = 20;
        for (int m = 0; m < 8; m++) begin
            drive(0, 0, m, 24'h123456, 0);
            drive(1300, 10, m, 24'h123456, 0);
            drive(10, 725, m, 24'h123456, 0);
            drive(1649, 749, m, 24'h123456, 0);
            drive(10, 10, m, 24'h123456, 0);
        end

        // Single-cycle reset in the middle of a BARS frame.
        phase = 30;
        drive(0, 0, 1, 24'hABCDEF, 0);
        run_line(400, 0, 699, 1, 24'hABCDEF);
        drive(700, 400, 1, 24'hABCDEF, 1);
        run_line(400, 701, 800, 1, 24'hABCDEF);
        phase = 31;
        run_line(0, 0, 200, 1, 24'hABCDEF);

        // Randomized cursor segments checked against the model.
        phase = 0;
        for (int s = 0; s < 60; s++) begin
            int y0, x0, len, md;
            if ($urandom_range(0, 3) == 0) begin
                drive(0, 0, int'($urandom_range(0, 7)), 24'($urandom), 0);
            end
            y0  = int'($urandom_range(0, 749));
            x0  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 1649));
            len = int'($urandom_range(1, 300));
            md  = int'($urandom_range(0, 7));
            for (int x = x0; x < x0 + len && x < 1650; x++) begin
                drive(x, y0, md, 24'($urandom), ($urandom_range(0, 199) == 0));
            end
        end
        drive(2000, 2000, 0, 24'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
